// File: rtl/csr_irq_unit_pkg.sv
// rtl/csr_irq_unit_pkg.sv - shared CSR addresses, SYSTEM encodings and trap FSM states
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] INSTR_MRET = 32'h3020_0073;

  // func3[1:0] selects the operation; func3[2] selects zimm as the source
  localparam logic [1:0] CSR_OP_RW = 2'b01;
  localparam logic [1:0] CSR_OP_RS = 2'b10;
  localparam logic [1:0] CSR_OP_RC = 2'b11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_BASE     = 16;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } trap_state_e;

endpackage

// File: rtl/csr_irq_unit_if.sv
// rtl/csr_irq_unit_if.sv - M-stage CSR access and redirect/flush bundle between pipeline and CSR unit
interface csr_irq_unit_if #(
  parameter int XLEN = 32
);
  logic            valid_m;
  logic [31:0]     instr_m;
  logic [XLEN-1:0] pc_m;
  logic [XLEN-1:0] rs1_m;
  logic [XLEN-1:0] csr_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;

  modport master (
    output valid_m, instr_m, pc_m, rs1_m,
    input  csr_rdata, redirect, redirect_pc, flush
  );

  modport slave (
    input  valid_m, instr_m, pc_m, rs1_m,
    output csr_rdata, redirect, redirect_pc, flush
  );
endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational lowest-index-wins priority encoder
module irq_prio_enc #(
  parameter  int NUM_IRQ = 4,
  localparam int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  // Scanning downward lets the lowest set bit overwrite the others last
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/csr_irq_unit.sv
// rtl/csr_irq_unit.sv - M-mode CSR file and prioritised interrupt controller; CSR_IRQ_SYNC_EN adds irq synchronisers
module csr_irq_unit
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0020
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  csr_irq_unit_if.slave      m,
  output logic [XLEN-1:0]    mcause_o
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [NUM_IRQ-1:0] irq_s;

`ifdef CSR_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] irq_meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_meta <= '0;
      irq_s    <= '0;
    end else begin
      irq_meta <= irq_i;
      irq_s    <= irq_meta;
    end
  end
`else
  assign irq_s = irq_i;
`endif

  trap_state_e     state;
  logic            mstatus_mie, mstatus_mpie;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic            redirect_q, flush_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic [XLEN-1:0] mstatus_rd, mip_rd, rdata;

  always_comb begin
    mstatus_rd                       = '0;
    mstatus_rd[MSTATUS_MIE]          = mstatus_mie;
    mstatus_rd[MSTATUS_MPIE]         = mstatus_mpie;
    mip_rd                           = '0;
    mip_rd[IRQ_BASE +: NUM_IRQ]      = irq_s;
  end

  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [4:0]  rs1_field;
  logic [11:0] csr_addr;

  assign opcode    = m.instr_m[6:0];
  assign func3     = m.instr_m[14:12];
  assign rs1_field = m.instr_m[19:15];
  assign csr_addr  = m.instr_m[31:20];

  always_comb begin
    rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:  rdata = mstatus_rd;
      CSR_MIE:      rdata = mie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MIP:      rdata = mip_rd;
      default:      rdata = '0;
    endcase
  end

  logic [NUM_IRQ-1:0] pending;
  logic               irq_any;
  logic [IDX_W-1:0]   irq_idx;

  assign pending = mip_rd[IRQ_BASE +: NUM_IRQ] & mie_q[IRQ_BASE +: NUM_IRQ];

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req (pending),
    .any (irq_any),
    .idx (irq_idx)
  );

  logic in_run, take_irq, take_mret, is_csr, csr_we;

  assign in_run    = (state == ST_RUN);
  assign take_irq  = m.valid_m && in_run && mstatus_mie && irq_any;
  assign take_mret = m.valid_m && in_run && !take_irq && (m.instr_m == INSTR_MRET);
  assign is_csr    = m.valid_m && in_run && (opcode == OPC_SYSTEM) && (func3[1:0] != 2'b00);
  // Set/clear with a zero source field are pure reads and must not touch the CSR
  assign csr_we    = is_csr && !take_irq && !((func3[1:0] != CSR_OP_RW) && (rs1_field == 5'd0));

  logic [XLEN-1:0] csr_src, csr_wdata;

  assign csr_src = func3[2] ? XLEN'(rs1_field) : m.rs1_m;

  always_comb begin
    case (func3[1:0])
      CSR_OP_RW: csr_wdata = csr_src;
      CSR_OP_RS: csr_wdata = rdata | csr_src;
      default:   csr_wdata = rdata & ~csr_src;
    endcase
  end

  logic [XLEN-2:0] cause_code;
  logic [XLEN-1:0] mtvec_base, trap_target;

  assign cause_code  = (XLEN-1)'(IRQ_BASE) + (XLEN-1)'(irq_idx);
  assign mtvec_base  = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_target = mtvec_q[0] ? mtvec_base + XLEN'({cause_code, 2'b00}) : mtvec_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RUN;
      mstatus_mie   <= 1'b0;
      mstatus_mpie  <= 1'b0;
      mie_q         <= '0;
      mtvec_q       <= MTVEC_RESET;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else if (state == ST_TRAP) begin
      state         <= ST_RUN;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else if (take_irq) begin
      mepc_q        <= m.pc_m;
      mcause_q      <= {1'b1, cause_code};
      mstatus_mpie  <= mstatus_mie;
      mstatus_mie   <= 1'b0;
      state         <= ST_TRAP;
      redirect_q    <= 1'b1;
      flush_q       <= 1'b1;
      redirect_pc_q <= trap_target;
    end else if (take_mret) begin
      mstatus_mie   <= mstatus_mpie;
      mstatus_mpie  <= 1'b1;
      state         <= ST_TRAP;
      redirect_q    <= 1'b1;
      flush_q       <= 1'b1;
      redirect_pc_q <= mepc_q;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie  <= csr_wdata[MSTATUS_MIE];
          mstatus_mpie <= csr_wdata[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_q      <= csr_wdata;
        CSR_MTVEC:    mtvec_q    <= {csr_wdata[XLEN-1:2], 1'b0, csr_wdata[0]};
        CSR_MSCRATCH: mscratch_q <= csr_wdata;
        CSR_MEPC:     mepc_q     <= csr_wdata;
        CSR_MCAUSE:   mcause_q   <= csr_wdata;
        default: ;
      endcase
    end
  end

  assign m.csr_rdata   = rdata;
  assign m.redirect    = redirect_q;
  assign m.flush       = flush_q;
  assign m.redirect_pc = redirect_pc_q;
  assign mcause_o      = mcause_q;

endmodule

// File: tb/tb_csr_irq_unit.sv
// tb/tb_csr_irq_unit.sv - randomized and directed checks of csr_irq_unit against a behavioural model
module tb_csr_irq_unit;

  localparam int NUM_IRQ = 4;
  localparam logic [31:0] IRQ_MASK = ((32'd1 << NUM_IRQ) - 32'd1) << 16;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] MRET = 32'h3020_0073;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_IRQ-1:0] irq = '0;
  logic [31:0] mcause;

  always #5 clk = ~clk;

  csr_irq_unit_if #(.XLEN(32)) bus ();

  csr_irq_unit #(.XLEN(32), .NUM_IRQ(NUM_IRQ), .MTVEC_RESET(32'h0000_0020)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_i    (irq),
    .m        (bus),
    .mcause_o (mcause)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: CSRs by address, a trap-pending flag and the expected redirect
  logic [31:0] csr_m [logic [11:0]];
  bit          m_trap;
  logic [31:0] m_redirect_pc;
  logic [NUM_IRQ-1:0] irq_d1, irq_d2;
  logic [31:0] last_rdata;

  function automatic logic [31:0] mip_now();
`ifdef CSR_IRQ_SYNC_EN
    return 32'(irq_d2) << 16;
`else
    return 32'(irq) << 16;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (a == 12'h344) return mip_now();
    if (csr_m.exists(a)) return csr_m[a];
    return 32'h0;
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h300: csr_m[a] = v & 32'h88;
      12'h305: csr_m[a] = v & ~32'h2;
      12'h304, 12'h340, 12'h341, 12'h342: csr_m[a] = v;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    csr_m.delete();
    csr_m[12'h300] = 0; csr_m[12'h304] = 0; csr_m[12'h305] = 32'h20;
    csr_m[12'h340] = 0; csr_m[12'h341] = 0; csr_m[12'h342] = 0;
    m_trap = 0; m_redirect_pc = 0; irq_d1 = '0; irq_d2 = '0;
  endtask

  task automatic model_step();
    logic [31:0] ins, pend, ms, tv, src, old;
    int cause;
    ins  = bus.instr_m;
    pend = mip_now() & csr_m[12'h304] & IRQ_MASK;
    ms   = csr_m[12'h300];
    if (m_trap) begin
      m_trap = 0;
      m_redirect_pc = 0;
    end else begin
      m_redirect_pc = 0;
      if (bus.valid_m && ms[3] && pend != 0) begin
        cause = 31;
        for (int i = 31; i >= 16; i--) if (pend[i]) cause = i;
        tv = csr_m[12'h305];
        m_redirect_pc = tv[0] ? (tv & ~32'h3) + 32'(4 * cause) : (tv & ~32'h3);
        csr_m[12'h341] = bus.pc_m;
        csr_m[12'h342] = 32'h8000_0000 | 32'(cause);
        csr_m[12'h300] = ms[3] ? 32'h80 : 32'h0;
        m_trap = 1;
      end else if (bus.valid_m && ins == MRET) begin
        m_redirect_pc = csr_m[12'h341];
        csr_m[12'h300] = 32'h80 | (ms[7] ? 32'h8 : 32'h0);
        m_trap = 1;
      end else if (bus.valid_m && ins[6:0] == 7'h73 && ins[13:12] != 2'b00) begin
        src = ins[14] ? 32'(ins[19:15]) : bus.rs1_m;
        old = model_read(ins[31:20]);
        if (ins[13:12] == 2'b01) model_write(ins[31:20], src);
        else if (ins[19:15] != 5'd0)
          model_write(ins[31:20], ins[13:12] == 2'b10 ? (old | src) : (old & ~src));
      end
    end
    irq_d2 = irq_d1;
    irq_d1 = irq;
  endtask

  task automatic check_outputs();
    chk("redirect", 32'(bus.redirect), 32'(m_trap));
    chk("flush", 32'(bus.flush), 32'(m_trap));
    chk("redirect_pc", bus.redirect_pc, m_redirect_pc);
    chk("mcause_o", mcause, csr_m[12'h342]);
  endtask

  task automatic do_cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] rs1, input logic [NUM_IRQ-1:0] irqv);
    bus.valid_m = v; bus.instr_m = ins; bus.pc_m = pc; bus.rs1_m = rs1; irq = irqv;
    #1;
    last_rdata = bus.csr_rdata;
    chk("csr_rdata", last_rdata, model_read(ins[31:20]));
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.valid_m = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] csr_ins(input logic [2:0] f3, input logic [4:0] fld, input logic [11:0] a);
    return {a, fld, f3, 5'd1, 7'b1110011};
  endfunction

  logic [11:0] addr_tab [8] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'h123};
  logic [2:0]  f3_tab   [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

  initial begin
    bus.valid_m = 0; bus.instr_m = NOP; bus.pc_m = 0; bus.rs1_m = 0;
    model_reset();
    apply_reset();

    // Reset values read through csrrs x0
    for (int i = 0; i < 8; i++) do_cycle(1, csr_ins(3'd2, 5'd0, addr_tab[i]), 0, 0, '0);
    do_cycle(1, csr_ins(3'd2, 5'd0, 12'h305), 0, 0, '0);
    chk("rst_mtvec", last_rdata, 32'h20);

    // Direct-mode trap on line 1
    do_cycle(1, csr_ins(3'd1, 5'd1, 12'h305), 32'h100, 32'h1000, '0);
    do_cycle(1, csr_ins(3'd1, 5'd1, 12'h304), 32'h104, 32'h0002_0000, '0);
    do_cycle(1, csr_ins(3'd1, 5'd1, 12'h300), 32'h108, 32'h8, '0);
    do_cycle(1, NOP, 32'h200, 0, 4'b0010);
    chk("trap_redirect", 32'(bus.redirect), 32'd1);
    chk("trap_pc", bus.redirect_pc, 32'h1000);
    chk("trap_mcause", mcause, 32'h8000_0011);
    do_cycle(1, csr_ins(3'd2, 5'd0, 12'h341), 32'h204, 0, 4'b0010);
    chk("trap_mepc", last_rdata, 32'h200);
    chk("trap_flush_done", 32'(bus.flush), 32'd0);
    do_cycle(1, csr_ins(3'd2, 5'd0, 12'h300), 32'h1000, 0, 4'b0010);
    chk("trap_mstatus", last_rdata, 32'h80);

    // mret, then immediate re-trap with the line still high
    do_cycle(1, MRET, 32'h1004, 0, 4'b0010);
    chk("mret_pc", bus.redirect_pc, 32'h200);
    do_cycle(1, csr_ins(3'd2, 5'd0, 12'h300), 32'h1008, 0, 4'b0010);
    chk("mret_mstatus", last_rdata, 32'h88);
    do_cycle(1, NOP, 32'h300, 0, 4'b0010);
    chk("retrap_redirect", 32'(bus.redirect), 32'd1);
    do_cycle(0, NOP, 0, 0, 4'b0010);

    // Vectored mode, lines 1 and 3 both pending
    do_cycle(1, csr_ins(3'd1, 5'd1, 12'h305), 32'h1000, 32'h1001, 4'b1010);
    do_cycle(1, csr_ins(3'd1, 5'd1, 12'h304), 32'h1004, 32'h000A_0000, 4'b1010);
    do_cycle(1, csr_ins(3'd6, 5'd8, 12'h300), 32'h1008, 0, 4'b1010);
    do_cycle(1, NOP, 32'h500, 0, 4'b1010);
    chk("vec_pc", bus.redirect_pc, 32'h1044);
    chk("vec_mcause", mcause, 32'h8000_0011);
    do_cycle(0, NOP, 0, 0, 4'b1010);

    // Immediate set/clear on mscratch
    do_cycle(1, csr_ins(3'd1, 5'd1, 12'h340), 32'h1048, 32'h55, 4'b1010);
    do_cycle(1, csr_ins(3'd6, 5'd0, 12'h340), 32'h104c, 0, 4'b1010);
    chk("csrrsi0_rdata", last_rdata, 32'h55);
    do_cycle(1, csr_ins(3'd7, 5'd5, 12'h340), 32'h1050, 0, 4'b1010);
    do_cycle(1, csr_ins(3'd2, 5'd0, 12'h340), 32'h1054, 0, 4'b1010);
    chk("csrrci_result", last_rdata, 32'h50);

    // Interrupt coincident with a CSR write
    do_cycle(1, csr_ins(3'd6, 5'd8, 12'h300), 32'h1058, 0, 4'b1010);
    do_cycle(1, csr_ins(3'd1, 5'd1, 12'h340), 32'h400, 32'hAA, 4'b1010);
    chk("coinc_redirect", 32'(bus.redirect), 32'd1);
    do_cycle(1, csr_ins(3'd2, 5'd0, 12'h340), 32'h1040, 0, 4'b1010);
    chk("coinc_mscratch", last_rdata, 32'h50);
    do_cycle(1, csr_ins(3'd2, 5'd0, 12'h341), 32'h1044, 0, 4'b1010);
    chk("coinc_mepc", last_rdata, 32'h400);

    // Reset while in TRAP
    do_cycle(1, csr_ins(3'd6, 5'd8, 12'h300), 32'h1048, 0, 4'b1010);
    do_cycle(1, NOP, 32'h600, 0, 4'b1010);
    chk("pre_rst_redirect", 32'(bus.redirect), 32'd1);
    apply_reset();
    chk("rst_trap_redirect", 32'(bus.redirect), 32'd0);
    chk("rst_trap_pc", bus.redirect_pc, 32'd0);
    do_cycle(1, csr_ins(3'd2, 5'd0, 12'h300), 32'h0, 0, 4'b1010);
    chk("rst_trap_mstatus", last_rdata, 32'h0);

    // Randomized phase
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] ins, rs1v;
      logic [4:0]  fld;
      int r;
      r = int'($urandom_range(0, 99));
      fld = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      if (r < 8) ins = MRET;
      else if (r < 80) ins = csr_ins(f3_tab[$urandom_range(0, 5)], fld, addr_tab[$urandom_range(0, 7)]);
      else ins = NOP;
      rs1v = $urandom;
      if ($urandom_range(0, 7) == 0) irq = NUM_IRQ'($urandom);
      do_cycle($urandom_range(0, 3) != 0, ins, $urandom & 32'hFFFF_FFFC, rs1v, irq);
      if ($urandom_range(0, 199) == 0) apply_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_irq_unit.md
Name: csr_irq_unit

Overview:
Machine-mode CSR file and interrupt controller for the 5-stage pipelined core, evaluated on the instruction in the M stage. It generalises single-line interrupt handling to NUM_IRQ prioritised level-sensitive lines and adds mcause, mscratch and vectored mtvec. A two-state trap FSM drives a one-cycle pipeline flush and PC redirect for trap entry and mret.

Parameters:
XLEN, 32, CSR/data width
NUM_IRQ, 4, external interrupt lines; line i maps to mip/mie bit 16+i; 1..16
MTVEC_RESET, 32'h0000_0020, mtvec reset value; bits[1:0] select mode

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
irq_i  in  NUM_IRQ  level-sensitive interrupt requests
valid_m  in  1  M-stage instruction is valid, retiring this cycle
instr_m  in  32  M-stage instruction
pc_m  in  XLEN  M-stage PC
rs1_m  in  XLEN  forwarded rs1 value for CSR instructions
csr_rdata  out  XLEN  old CSR value for rd writeback; combinational from instr_m[31:20]
redirect  out  1  one-cycle PC redirect strobe
redirect_pc  out  XLEN  redirect target, valid while redirect=1
flush  out  1  flush IF/ID/EX/MEM; same cycle as redirect
mcause_o  out  XLEN  current mcause, for debug

Behaviour:
- Reset values: mstatus=0, mie=0, mepc=0, mcause=0, mscratch=0, mtvec=MTVEC_RESET. Reset also forces state RUN and drives redirect=0, flush=0 and redirect_pc=0. Reset taken in TRAP aborts the trap; no CSR update from that trap.
- Addresses: mstatus 0x300 (bits 3 MIE, 7 MPIE), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344.
- mip is read-only: bit 16+i = synchronised irq_i[i]; other bits read 0. Unmapped address: read 0, write ignored.
- CSR ops apply only when valid_m=1 and opcode=7'b1110011:
  - func3 1/5 = RW, 2/6 = RS, 3/7 = RC.
  - func3 5–7 use zimm = instr_m[19:15], zero-extended, in place of rs1_m.
  - RS/RC with rs1 field = 0: no write.
  - Write takes effect at the next clk edge; csr_rdata shows the pre-write value.
- Pending set P = mip & mie over bits 16..16+NUM_IRQ-1. Take an interrupt when P≠0, mstatus.MIE=1, valid_m=1 and state=RUN.
- Priority: lowest index wins.
- Trap entry, at the clk edge:
  - mepc <= pc_m.
  - mcause <= {1'b1, (16+i) zero-extended to XLEN-1}.
  - MPIE <= MIE; MIE <= 0.
  - M-stage instruction does not retire; its CSR write is suppressed.
  - FSM RUN -> TRAP.
- mret (instr_m = 32'h30200073, valid_m=1, no interrupt taken): MIE <= MPIE; MPIE <= 1; FSM RUN -> TRAP with target = mepc.
- TRAP lasts exactly 1 cycle, then returns to RUN:
  - flush=1, redirect=1 during TRAP.
  - Trap target: redirect_pc = {mtvec[XLEN-1:2],2'b00} in direct mode (mtvec[1:0]=0); base + 4*cause_code in vectored mode (mtvec[1:0]=1).
  - mret target: redirect_pc = the mepc value captured at the mret edge.
  - Interrupts are not evaluated in TRAP. An instruction arriving in TRAP is flushed and has no effect.
- Simultaneous events:
  - Interrupt with mret: interrupt wins; mepc = pc of the mret.
  - Interrupt with a CSR write to mstatus/mie: interrupt evaluated on pre-write values; write dropped.
- mtvec writes force bit 1 to 0 (modes 0/1 only).
- Latency: irq_i assertion to redirect is 1 cycle after a valid M instruction with the enable conditions met, plus synchroniser delay.

Optional Feature:
CSR_IRQ_SYNC_EN:
- Defined: each irq_i bit passes through a 2-flop synchroniser (reset 0) before mip; adds 2 cycles of latency.
- Undefined: mip samples irq_i directly (same-clock sources only).

Decomposition:
- Package csr_pkg: CSR address localparams, SYSTEM opcode, func3 codes, MRET encoding, mstatus bit indices, state enum {RUN, TRAP}.
- Sub-module irq_prio_enc(NUM_IRQ): combinational lowest-index priority encoder producing any/index. Reused by a future PLIC.

Test Plan:
- Reset, then read each CSR via csrrs x0 -> mtvec=0x20; all others 0; redirect=0.
- csrrw mtvec=0x1000, mie bit17=1, mstatus=0x8; irq_i=4'b0010 at pc_m=0x200 -> mepc=0x200, mcause=0x80000011, MIE=0, MPIE=1, redirect_pc=0x1000, flush 1 cycle.
- Vectored mode: mtvec=0x1001, irq lines 1 and 3 both pending and enabled -> line 1 wins, redirect_pc=0x1044.
- mret after trap -> redirect_pc=mepc (0x200), MIE=1, MPIE=1; with irq still high, a new trap is taken on the next valid M instruction.
- csrrsi with zimm=0 on mscratch=0x55 -> rdata=0x55, no write. csrrci with zimm=5 -> mscratch=0x50.
- Interrupt coincident with csrrw mscratch=0xAA -> mscratch unchanged; mepc = that instruction's PC. Assert rst during TRAP -> redirect=0 next cycle, state RUN.
